// File: rtl/result_bcd_display.sv
// result_bcd_display: converts a WIDTH-bit multiplier result to packed BCD
// with a sequential shift-add-3 (double-dabble) engine, and scans the result
// onto a multiplexed active-low 7-segment display with leading-zero blanking.
// Optional feature macro: SIGNED_RESULT_EN -- treat `value` as two's
// complement and show a minus sign left of the most significant digit.
module result_bcd_display #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int BW    = 4 * DIGITS;
  localparam int SC_W  = $clog2(WIDTH + 1);
  localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t           state, state_nxt;
  logic [SC_W-1:0]  shift_cnt;
  logic [WIDTH-1:0] mag, mag_in;
  logic [BW-1:0]    work, work_adj;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // Magnitude of the incoming value (two's complement negation when signed).
`ifdef SIGNED_RESULT_EN
  logic sign_r;
  always_comb begin
    mag_in = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
  end
`else
  always_comb begin
    mag_in = value;
  end
`endif

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments with an async
  // active-low reset so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state and busy decode.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (shift_cnt == SC_W'(WIDTH - 1)) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that would overflow when doubled.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture, shift, and publish to the output buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_cnt <= '0;
      mag       <= '0;
      work      <= '0;
      bcd       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mag       <= mag_in;
          work      <= '0;
          shift_cnt <= '0;
        end
        SHIFT: begin
          {work, mag} <= {work_adj, mag} << 1;
          shift_cnt   <= shift_cnt + SC_W'(1);
        end
        LOAD: begin
          bcd  <= work;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNED_RESULT_EN
  // Sign capture at accept; published together with bcd in LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_r   <= 1'b0;
      negative <= 1'b0;
    end else begin
      if (state == IDLE && start) sign_r <= value[WIDTH-1];
      if (state == LOAD)          negative <= sign_r;
    end
  end
`else
  assign negative = 1'b0;
`endif

  logic [RC_W-1:0]  refresh_cnt;
  logic [IDX_W-1:0] digit_idx, msd, minus_pos;
  logic [3:0]       cur_digit;
  logic [6:0]       seg_nxt;

  // Free-running refresh counter and digit index for the display scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RC_W'(1);
    end
  end

  // Segment pattern for the digit currently scanned: digit, blank or minus.
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) cur_digit = bcd[4*i +: 4];
    end
    // When the top digit is significant, minus_pos equals DIGITS and never matches.
    minus_pos = msd + IDX_W'(1);
    if (negative && digit_idx == minus_pos) seg_nxt = 7'h3F;
    else if (digit_idx > msd)               seg_nxt = 7'h7F;
    else                                    seg_nxt = seg_code(cur_digit);
  end

  // Registered display pins so seg and an always switch on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 7'h40;
      an  <= ~DIGITS'(1);
    end else begin
      seg <= seg_nxt;
      an  <= ~(DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: tb/tb_result_bcd_display.sv
// Self-checking bench for result_bcd_display: randomized and directed
// conversions compared against an arithmetic decimal model, plus display scan,
// held-start and mid-conversion reset scenarios.
module tb_result_bcd_display;

  localparam int WIDTH       = 16;
  localparam int DIGITS      = 5;
  localparam int REFRESH_DIV = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [WIDTH-1:0]    value = '0;
  logic                busy, done, negative;
  logic [4*DIGITS-1:0] bcd;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;

  int n_cmp = 0;
  int n_err = 0;
  int an_bad = 0;

  logic [4*DIGITS-1:0] last_bcd = '0;
  logic                last_neg = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  result_bcd_display #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .negative(negative),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Exactly one digit enable must be low whenever out of reset.
  always @(negedge clk) begin
    if (rst && $countones(~an) != 1) an_bad++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the value.
  function automatic int model_mag(input logic [WIDTH-1:0] v);
`ifdef SIGNED_RESULT_EN
    if (v[WIDTH-1]) return (2 ** WIDTH) - int'(v);
`endif
    return int'(v);
  endfunction

  function automatic logic model_neg(input logic [WIDTH-1:0] v);
`ifdef SIGNED_RESULT_EN
    return v[WIDTH-1] && (v != '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4*DIGITS-1:0] model_bcd(input int m);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input logic [WIDTH-1:0] v, input int pos);
    int m, top, p;
    int d [DIGITS];
    m   = model_mag(v);
    p   = 1;
    top = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = (m / p) % 10;
      if (d[i] != 0) top = i;
      p = p * 10;
    end
    if (pos > top) return (model_neg(v) && pos == top + 1) ? 7'h3F : 7'h7F;
    return seg_tab[d[pos]];
  endfunction

  // One conversion: start pulse, then track busy/done over a bounded window.
  task automatic run_conv(input logic [WIDTH-1:0] v, input string tag);
    int busy_cnt, done_cnt, first_done;
    busy_cnt   = 0;
    done_cnt   = 0;
    first_done = -1;
    value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    value = WIDTH'($urandom);
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) tick();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (k == 8) check({tag, "_bcd_hold"}, bcd, last_bcd);
    end
    check({tag, "_done_at"}, first_done, 17);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_cnt"}, busy_cnt, 17);
    check({tag, "_bcd"}, bcd, model_bcd(model_mag(v)));
    check({tag, "_neg"}, negative, model_neg(v));
    last_bcd = model_bcd(model_mag(v));
    last_neg = model_neg(v);
  endtask

  // Walk the scan and compare each digit's segments against the model.
  task automatic check_display(input logic [WIDTH-1:0] v, input string tag);
    bit found;
    tick();
    tick();
    for (int pos = 0; pos < DIGITS; pos++) begin
      found = 1'b0;
      for (int c = 0; c < 4 * REFRESH_DIV * DIGITS && !found; c++) begin
        if (an == ~(DIGITS'(1) << pos)) found = 1'b1;
        else tick();
      end
      check($sformatf("%s_an%0d", tag, pos), found, 1'b1);
      if (found) check($sformatf("%s_seg%0d", tag, pos), seg, model_seg(v, pos));
    end
  endtask

  initial begin
    int done_cnt, first_done;
    logic [WIDTH-1:0] v;

    // Reset state.
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd, '0);
    check("rst_neg", negative, 1'b0);
    check("rst_an", an, 5'b11110);
    check("rst_seg", seg, 7'h40);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Directed values, including boundaries.
    run_conv(16'd12345, "v12345");  check_display(16'd12345, "d12345");
    run_conv(16'd0,     "v0");      check_display(16'd0,     "d0");
    run_conv(16'hFFFF,  "vffff");   check_display(16'hFFFF,  "dffff");
    run_conv(16'hFFD6,  "vffd6");   check_display(16'hFFD6,  "dffd6");
    run_conv(16'h8000,  "v8000");   check_display(16'h8000,  "d8000");
    run_conv(16'd10,    "v10");     check_display(16'd10,    "d10");
    run_conv(16'hFFFF,  "vffff_b");
    run_conv(16'd9,     "v9");

    // Randomized values.
    for (int r = 0; r < 20; r++) begin
      v = WIDTH'($urandom);
      run_conv(v, $sformatf("rnd%0d", r));
      if (r % 5 == 0) check_display(v, $sformatf("drnd%0d", r));
    end

    // Start held high while value changes: one done, first value converted.
    v = 16'd4321;
    value = v;
    start = 1'b1;
    tick();
    done_cnt   = 0;
    first_done = -1;
    for (int k = 1; k <= 30; k++) begin
      value = WIDTH'($urandom);
      tick();
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (k == 16) start = 1'b0;
    end
    check("held_done_cnt", done_cnt, 1);
    check("held_done_at", first_done, 17);
    check("held_bcd", bcd, model_bcd(model_mag(v)));
    check("held_busy", busy, 1'b0);
    last_bcd = model_bcd(model_mag(v));
    last_neg = model_neg(v);

    // Reset asserted in cycle 8 of a conversion aborts it.
    value = 16'd54321;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bcd", bcd, '0);
    check("abort_neg", negative, 1'b0);
    check("abort_an", an, 5'b11110);
    check("abort_seg", seg, 7'h40);
    tick();
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    last_bcd = '0;
    last_neg = 1'b0;
    run_conv(16'd99, "v99");
    check_display(16'd99, "d99");

    check("an_onehot", an_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
